uart_frame_parser: RTL and testbench

UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_timeout_timer.sv | 26 ++
 rtl/uart_frame_parser.sv | 119 +++++++++++
 tb/tb_uart_frame_parser.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants for the UART frame parser
//   SOF        start-of-frame byte
//   CHAR_BITS  bits per UART character (start + 8 data + stop)
//   ST_*       frame parser state encoding
package uart_pkg;
    localparam logic [7:0] SOF       = 8'hA5;
    localparam int         CHAR_BITS = 10;
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LEN     = 3'd1;
    localparam logic [2:0] ST_PAYLOAD = 3'd2;
    localparam logic [2:0] ST_CHK     = 3'd3;
    localparam logic [2:0] ST_HOLD    = 3'd4;
endpackage

// File: rtl/uart_timeout_timer.sv
// uart_timeout_timer: inter-byte gap counter with one-cycle expiry strobe
//   clk, n_rst  clock, asynchronous active-low reset
//   clear       restart the gap (a byte arrived); wins over expiry
//   enable      count while high, held at zero while low
//   expired     high for the single cycle in which the gap reaches LIMIT
module uart_timeout_timer #(
    parameter int LIMIT = 17360
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt;

    assign expired = enable && !clear && (cnt == W'(LIMIT - 1));

    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst)
            cnt <= '0;
        else
            cnt <= (clear || !enable || expired) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_frame_parser.sv
// uart_frame_parser: parses SOF/LEN/payload/CHK frames from a UART RX byte stream
//   clk, n_rst            clock, asynchronous active-low reset
//   rx_data, rx_valid     byte and one-cycle strobe straight from the UART receiver
//   rd_addr, rd_data      combinational payload read port (0x00 beyond frame_len)
//   frame_len             payload length of the held frame
//   frame_ready           a checked frame is held until frame_ack
//   frame_ack             consumer releases the held frame
//   crc_err, len_err,
//   timeout_err, drop_err one-cycle error strobes
module uart_frame_parser
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ    = 50_000_000,
    parameter int BAUD_RATE     = 115_200,
    parameter int MAX_LEN       = 16,
    parameter int TIMEOUT_BYTES = 4
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_valid,
    input  logic [$clog2(MAX_LEN)-1:0] rd_addr,
    output logic [7:0]                 rd_data,
    output logic [$clog2(MAX_LEN):0]   frame_len,
    output logic                       frame_ready,
    input  logic                       frame_ack,
    output logic                       crc_err,
    output logic                       len_err,
    output logic                       timeout_err,
    output logic                       drop_err
);
    localparam int AW    = $clog2(MAX_LEN);
    localparam int LIMIT = TIMEOUT_BYTES * CHAR_BITS * (CLOCK_FREQ / BAUD_RATE);

    logic [2:0]    state;
    logic [AW:0]   len_q;
    logic [AW-1:0] idx;
    logic [7:0]    acc;
    logic [7:0]    buf_q [MAX_LEN];
    logic          expired;

    uart_timeout_timer #(.LIMIT(LIMIT)) u_timer (
        .clk     (clk),
        .n_rst   (n_rst),
        .clear   (rx_valid),
        .enable  (state == ST_LEN || state == ST_PAYLOAD || state == ST_CHK),
        .expired (expired)
    );

    assign frame_ready = (state == ST_HOLD);
    assign rd_data     = ({1'b0, rd_addr} < frame_len) ? buf_q[rd_addr] : 8'h00;

    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) begin
            state       <= ST_IDLE;
            len_q       <= '0;
            idx         <= '0;
            acc         <= 8'h00;
            frame_len   <= '0;
            crc_err     <= 1'b0;
            len_err     <= 1'b0;
            timeout_err <= 1'b0;
            drop_err    <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++)
                buf_q[i] <= 8'h00;
        end else begin
            crc_err     <= 1'b0;
            len_err     <= 1'b0;
            timeout_err <= 1'b0;
            drop_err    <= 1'b0;
            if (expired) begin
                state       <= ST_IDLE;
                timeout_err <= 1'b1;
            end else
                case (state)
                    ST_IDLE:
                        if (rx_valid && rx_data == SOF)
                            state <= ST_LEN;
                    ST_LEN:
                        if (rx_valid) begin
                            if (rx_data != 8'h00 && rx_data <= 8'(MAX_LEN)) begin
                                len_q <= rx_data[AW:0];
                                acc   <= rx_data;
                                idx   <= '0;
                                state <= ST_PAYLOAD;
                            end else begin
                                len_err <= 1'b1;
                                state   <= ST_IDLE;
                            end
                        end
                    ST_PAYLOAD:
                        if (rx_valid) begin
                            buf_q[idx] <= rx_data;
                            acc        <= acc ^ rx_data;
                            idx        <= idx + 1'b1;
                            if ({1'b0, idx} == len_q - 1'b1)
                                state <= ST_CHK;
                        end
                    ST_CHK:
                        if (rx_valid) begin
                            if (rx_data == acc) begin
                                frame_len <= len_q;
                                state     <= ST_HOLD;
                            end else begin
                                crc_err <= 1'b1;
                                state   <= ST_IDLE;
                            end
                        end
                    ST_HOLD:
                        // a byte arriving with the release is parsed as if already in IDLE
                        if (frame_ack)
                            state <= (rx_valid && rx_data == SOF) ? ST_LEN : ST_IDLE;
                        else if (rx_valid)
                            drop_err <= 1'b1;
                    default:
                        state <= ST_IDLE;
                endcase
        end
endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser: directed self-checking bench for uart_frame_parser
module tb_uart_frame_parser;
    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [3:0] rd_addr = 4'd0;
    logic [7:0] rd_data;
    logic [4:0] frame_len;
    logic       frame_ready;
    logic       frame_ack = 1'b0;
    logic       crc_err, len_err, timeout_err, drop_err;
    int         checks = 0;
    int         failures = 0;
    int         err_cnt = 0;
    int         err_base;

    uart_frame_parser dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .frame_len   (frame_len),
        .frame_ready (frame_ready),
        .frame_ack   (frame_ack),
        .crc_err     (crc_err),
        .len_err     (len_err),
        .timeout_err (timeout_err),
        .drop_err    (drop_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        err_cnt += int'(crc_err) + int'(len_err) + int'(timeout_err) + int'(drop_err);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic ack();
        @(negedge clk);
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
        rd_addr = a;
        #1;
        chk(tag, {24'h0, rd_data}, {24'h0, exp});
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'h0, frame_ready}, 0);
        chk("rst_len", {27'h0, frame_len}, 0);
        chk("rst_rd", {24'h0, rd_data}, 0);
        chk("rst_errs", {28'h0, crc_err, len_err, timeout_err, drop_err}, 0);
        n_rst = 1'b1;

        // leading garbage, then a good 3-byte frame
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
        send_byte(8'hA5); send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        chk("f1_ready_pre", {31'h0, frame_ready}, 0);
        send_byte(8'h03);
        chk("f1_ready", {31'h0, frame_ready}, 1);
        chk("f1_len", {27'h0, frame_len}, 3);
        read_chk("f1_rd0", 4'd0, 8'h11);
        read_chk("f1_rd1", 4'd1, 8'h22);
        read_chk("f1_rd2", 4'd2, 8'h33);
        read_chk("f1_rd3", 4'd3, 8'h00);
        chk("f1_no_err", err_cnt, 0);

        // bytes while holding are dropped
        err_base = err_cnt;
        send_byte(8'hA5);
        chk("drop1", {31'h0, drop_err}, 1);
        send_byte(8'h01);
        chk("drop2", {31'h0, drop_err}, 1);
        @(negedge clk);
        chk("drop_clear", {31'h0, drop_err}, 0);
        chk("drop_count", err_cnt - err_base, 2);
        chk("hold_len", {27'h0, frame_len}, 3);
        read_chk("hold_rd1", 4'd1, 8'h22);
        chk("hold_ready", {31'h0, frame_ready}, 1);

        // release coincident with SOF: no drop, parser goes straight to LEN
        @(negedge clk);
        rx_data = 8'hA5; rx_valid = 1'b1; frame_ack = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0; frame_ack = 1'b0;
        chk("ack_sof_drop", {31'h0, drop_err}, 0);
        chk("ack_sof_ready", {31'h0, frame_ready}, 0);
        send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
        chk("ack_sof_frame", {31'h0, frame_ready}, 1);
        chk("ack_sof_len", {27'h0, frame_len}, 1);
        read_chk("ack_sof_rd0", 4'd0, 8'h7E);
        ack();
        chk("ack_ready", {31'h0, frame_ready}, 0);

        // checksum error, then a good frame
        err_base = err_cnt;
        send_byte(8'hA5); send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h04);
        chk("crc_strobe", {31'h0, crc_err}, 1);
        chk("crc_ready", {31'h0, frame_ready}, 0);
        @(negedge clk);
        chk("crc_clear", {31'h0, crc_err}, 0);
        chk("crc_count", err_cnt - err_base, 1);
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'hAA); send_byte(8'h55); send_byte(8'hFD);
        chk("f2_ready", {31'h0, frame_ready}, 1);
        chk("f2_len", {27'h0, frame_len}, 2);
        read_chk("f2_rd0", 4'd0, 8'hAA);
        read_chk("f2_rd1", 4'd1, 8'h55);
        read_chk("f2_rd2", 4'd2, 8'h00);
        ack();

        // length errors at both ends
        err_base = err_cnt;
        send_byte(8'hA5); send_byte(8'h00);
        chk("len0", {31'h0, len_err}, 1);
        send_byte(8'hA5); send_byte(8'h11);
        chk("len17", {31'h0, len_err}, 1);
        @(negedge clk);
        chk("len_count", err_cnt - err_base, 2);

        // maximum length frame: payload 0..15, XOR of payload is 0, so CHK = 0x10
        send_byte(8'hA5); send_byte(8'h10);
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        send_byte(8'h10);
        chk("max_ready", {31'h0, frame_ready}, 1);
        chk("max_len", {27'h0, frame_len}, 16);
        read_chk("max_rd15", 4'd15, 8'h0F);
        read_chk("max_rd7", 4'd7, 8'h07);
        ack();

        // timeout: 4 chars * 10 bits * 434 clocks = 17360 cycles of gap
        err_base = err_cnt;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
        repeat (17359) @(negedge clk);
        chk("tmo_early", {31'h0, timeout_err}, 0);
        @(negedge clk);
        chk("tmo_strobe", {31'h0, timeout_err}, 1);
        @(negedge clk);
        chk("tmo_clear", {31'h0, timeout_err}, 0);
        chk("tmo_ready", {31'h0, frame_ready}, 0);
        chk("tmo_count", err_cnt - err_base, 1);

        // asynchronous reset mid-frame
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        #2 n_rst = 1'b0;
        #1;
        chk("mid_rst_ready", {31'h0, frame_ready}, 0);
        chk("mid_rst_len", {27'h0, frame_len}, 0);
        read_chk("mid_rst_rd", 4'd0, 8'h00);
        chk("mid_rst_errs", {28'h0, crc_err, len_err, timeout_err, drop_err}, 0);
        @(negedge clk);
        n_rst = 1'b1;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
        chk("post_rst_ready", {31'h0, frame_ready}, 1);
        read_chk("post_rst_rd0", 4'd0, 8'h7E);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
